// File: rtl/race_input_conditioner.sv
// race_input_conditioner
//   Synchronises and debounces the three raw race-game push-buttons and
//   turns them into the levels the race controller samples on its slow
//   divided clocks.
//
// Ports
//   clk         in   system clock
//   rst         in   asynchronous active-low reset
//   btn_en      in   raw enable button (asynchronous, bouncing)
//   btn_speed   in   raw speed button (asynchronous, bouncing)
//   btn_freeze  in   raw freeze button (asynchronous, bouncing)
//   en          out  press-to-toggle enable level
//   speed       out  speed request, stretched to STRETCH_CYCLES clocks
//   freeze      out  debounced freeze level
//   btn_db      out  debounced levels {freeze, speed, en} for debug LEDs
//   speed_state out  speed FSM state (0 = IDLE, 1 = STRETCH) for debug
//
// Handshake: none. All inputs are free-running levels; all outputs are
// registered levels that are valid every cycle.

module race_input_conditioner #(
  parameter int unsigned DB_CYCLES      = 1_000_000,
  parameter int unsigned STRETCH_CYCLES = 16_777_216
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_en,
  input  logic       btn_speed,
  input  logic       btn_freeze,
  output logic       en,
  output logic       speed,
  output logic       freeze,
  output logic [2:0] btn_db,
  output logic       speed_state
);

  localparam int unsigned CW = $clog2(DB_CYCLES);
  localparam int unsigned SW = $clog2(STRETCH_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
  localparam logic [SW-1:0] ST_LAST = SW'(STRETCH_CYCLES - 1);

  // Channel order matches btn_db: 0 = en, 1 = speed, 2 = freeze.
  logic [2:0]    raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    s;
  logic [1:0]    s_d;     // only en and speed need edge detection
  logic [CW-1:0] cnt [3];
  logic          rise_en;
  logic          rise_speed;

  assign raw = {btn_freeze, btn_speed, btn_en};

  // Synchronisers and debouncers. A level is accepted only after it has
  // differed from the stable level for DB_CYCLES consecutive cycles; any
  // return to the stable level restarts the count, so it never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      s     <= '0;
      s_d   <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      s_d   <= s[1:0];
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == s[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          s[i]   <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign rise_en    = s[0] & ~s_d[0];
  assign rise_speed = s[1] & ~s_d[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         en <= 1'b0;
    else if (rise_en) en <= ~en;
  end

  // Speed stretcher. It looks at the registered en, i.e. the value before
  // any toggle landing in the same cycle: a press that turns en off still
  // starts a pulse (aborted a cycle later), one that turns en on does not.
  typedef enum logic {
    IDLE    = 1'b0,
    STRETCH = 1'b1
  } speed_state_t;

  speed_state_t  state, state_nx;
  logic [SW-1:0] scnt, scnt_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      scnt  <= '0;
    end else begin
      state <= state_nx;
      scnt  <= scnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    scnt_nx  = scnt;
    case (state)
      IDLE: begin
        if (rise_speed && en) begin
          state_nx = STRETCH;
          scnt_nx  = ST_LAST;
        end
      end
      STRETCH: begin
        // Rises seen here are dropped: the pulse cannot be retriggered.
        if (!en || scnt == '0) begin
          state_nx = IDLE;
          scnt_nx  = '0;
        end else begin
          scnt_nx = scnt - SW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        scnt_nx  = '0;
      end
    endcase
  end

  assign speed       = (state == STRETCH);
  assign speed_state = state;
  assign freeze      = s[2];
  assign btn_db      = s;

endmodule

// File: tb/tb_race_input_conditioner.sv
module tb_race_input_conditioner;

  localparam int unsigned DB = 4;
  localparam int unsigned ST = 8;

  // Observed vector layout: {btn_db[2:0], en, speed, freeze}.
  localparam logic [5:0] M_FRZ = 6'b000001;
  localparam logic [5:0] M_SPD = 6'b000010;
  localparam logic [5:0] M_EN  = 6'b000100;
  localparam logic [5:0] M_DB0 = 6'b001000;
  localparam logic [5:0] M_DB1 = 6'b010000;
  localparam logic [5:0] M_ALL = 6'b111111;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_en = 1'b0;
  logic       btn_speed = 1'b0;
  logic       btn_freeze = 1'b0;
  logic       en;
  logic       speed;
  logic       freeze;
  logic [2:0] btn_db;
  logic       speed_state;

  // Scoreboard entries are {mask[5:0], expected[5:0]}.
  logic [11:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  race_input_conditioner #(
    .DB_CYCLES      (DB),
    .STRETCH_CYCLES (ST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_en      (btn_en),
    .btn_speed   (btn_speed),
    .btn_freeze  (btn_freeze),
    .en          (en),
    .speed       (speed),
    .freeze      (freeze),
    .btn_db      (btn_db),
    .speed_state (speed_state)
  );

  function automatic logic [5:0] obs();
    return {btn_db, en, speed, freeze};
  endfunction

  // ---- driver tasks ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_en();
    btn_en = 1'b1;
    idle(6);
    btn_en = 1'b0;
    idle(10);
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    logic [11:0] e;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({M_ALL, 6'b000000});
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if ((obs() & e[11:6]) !== e[5:0]) begin
        n_err++;
        $display("FAIL reset cyc %0d: got %b need %b", i, obs(), e[5:0]);
      end
    end
    n_vec++;
    if (speed_state !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got %b need 0", speed_state);
    end
    @(posedge clk);
    #3 rst = 1'b1;
  endtask

  task automatic test_en_press();
    logic [11:0] e;
    logic en0, db_e, en_e;
    for (int p = 0; p < 2; p++) begin
      en0 = (p == 1);
      for (int i = 0; i < 30; i++) begin
        btn_en = (i < 20);
        db_e = (i >= 5 && i < 25);
        en_e = (i >= 6) ? ~en0 : en0;
        exp_q.push_back({M_DB0 | M_EN, 2'b00, db_e, en_e, 2'b00});
        tick();
        e = exp_q.pop_front();
        n_vec++;
        if ((obs() & e[11:6]) !== e[5:0]) begin
          n_err++;
          $display("FAIL en_press p%0d cyc %0d: got %b need %b (mask %b)",
                   p, i, obs() & e[11:6], e[5:0], e[11:6]);
        end
      end
    end
  endtask

  task automatic test_bounce();
    logic [11:0] e;
    logic [7:0]  pat;
    logic        fr_e;
    pat = 8'b0111_0111;  // raw 1,1,1,0,1,1,1,0 from bit 0 upward
    for (int i = 0; i < 25; i++) begin
      btn_freeze = (i < 8) ? pat[i] : (i < 17);
      // last raw 0->1 lands at cycle 8, so freeze rises DB+1 later
      fr_e = (i >= 13 && i < 22);
      exp_q.push_back({M_FRZ | M_EN, 3'b000, 1'b0, 1'b0, fr_e});
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if ((obs() & e[11:6]) !== e[5:0]) begin
        n_err++;
        $display("FAIL bounce cyc %0d: got %b need %b (mask %b)",
                 i, obs() & e[11:6], e[5:0], e[11:6]);
      end
    end
  endtask

  task automatic test_speed_gated();
    logic [11:0] e;
    logic        db1_e;
    for (int i = 0; i < 20; i++) begin
      btn_speed = (i < 10);
      db1_e = (i >= 5 && i < 15);
      exp_q.push_back({M_DB1 | M_SPD | M_EN, 1'b0, db1_e, 4'b0000});
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if ((obs() & e[11:6]) !== e[5:0]) begin
        n_err++;
        $display("FAIL speed_gated cyc %0d: got %b need %b (mask %b)",
                 i, obs() & e[11:6], e[5:0], e[11:6]);
      end
    end
  endtask

  // Both buttons pressed together; en0 is the en level before the press.
  task automatic test_simultaneous(input logic en0);
    logic [11:0] e;
    logic        en_e, sp_e;
    for (int i = 0; i < 20; i++) begin
      btn_en    = (i < 6);
      btn_speed = (i < 6);
      en_e = (i >= 6) ? ~en0 : en0;
      sp_e = en0 && (i == 6);
      exp_q.push_back({M_EN | M_SPD, 3'b000, en_e, sp_e, 1'b0});
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if ((obs() & e[11:6]) !== e[5:0]) begin
        n_err++;
        $display("FAIL simultaneous en0=%0b cyc %0d: got %b need %b (mask %b)",
                 en0, i, obs() & e[11:6], e[5:0], e[11:6]);
      end
    end
  endtask

  task automatic test_speed_pulse();
    logic [11:0] e;
    logic        sp_e, db1_e;
    for (int i = 0; i < 30; i++) begin
      // second clean press is accepted while the first pulse is still high
      btn_speed = (i < 4) || (i >= 8 && i < 16);
      sp_e  = (i >= 6 && i <= 13);
      db1_e = (i >= 5 && i < 9) || (i >= 13 && i < 21);
      exp_q.push_back({M_DB1 | M_SPD | M_EN, 1'b0, db1_e, 1'b0, 1'b1, sp_e, 1'b0});
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if ((obs() & e[11:6]) !== e[5:0]) begin
        n_err++;
        $display("FAIL speed_pulse cyc %0d: got %b need %b (mask %b)",
                 i, obs() & e[11:6], e[5:0], e[11:6]);
      end
    end
  endtask

  task automatic test_abort();
    logic [11:0] e;
    logic        en_e, sp_e;
    for (int i = 0; i < 25; i++) begin
      btn_speed = (i < 6);
      btn_en    = (i >= 3 && i < 9);
      en_e = (i < 9);
      sp_e = (i >= 6 && i <= 9);
      exp_q.push_back({M_EN | M_SPD, 3'b000, en_e, sp_e, 1'b0});
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if ((obs() & e[11:6]) !== e[5:0]) begin
        n_err++;
        $display("FAIL abort cyc %0d: got %b need %b (mask %b)",
                 i, obs() & e[11:6], e[5:0], e[11:6]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [11:0] e;
    logic        sp_e, fr_e, en_e;
    for (int i = 0; i < 9; i++) begin
      btn_speed  = (i < 6);
      btn_freeze = (i < 6);
      sp_e = (i >= 6);
      fr_e = (i >= 5);
      exp_q.push_back({M_EN | M_SPD | M_FRZ, 3'b000, 1'b1, sp_e, fr_e});
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if ((obs() & e[11:6]) !== e[5:0]) begin
        n_err++;
        $display("FAIL async_pre cyc %0d: got %b need %b (mask %b)",
                 i, obs() & e[11:6], e[5:0], e[11:6]);
      end
    end
    // assert reset between edges, mid-stretch, with en held down
    btn_en = 1'b1;
    #2 rst = 1'b0;
    exp_q.push_back({M_ALL, 6'b000000});
    #1;
    e = exp_q.pop_front();
    n_vec++;
    if ((obs() & e[11:6]) !== e[5:0]) begin
      n_err++;
      $display("FAIL async_assert: got %b need %b", obs(), e[5:0]);
    end
    btn_speed  = 1'b0;
    btn_freeze = 1'b0;
    idle(3);
    exp_q.push_back({M_ALL, 6'b000000});
    e = exp_q.pop_front();
    n_vec++;
    if ((obs() & e[11:6]) !== e[5:0]) begin
      n_err++;
      $display("FAIL async_hold: got %b need %b", obs(), e[5:0]);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    // first edge after release (i = 0) is where sync1 samples the held
    // button, so en lands six edges later
    for (int i = 0; i < 14; i++) begin
      en_e = (i >= 6);
      exp_q.push_back({M_EN | M_SPD | M_FRZ, 3'b000, en_e, 2'b00});
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if ((obs() & e[11:6]) !== e[5:0]) begin
        n_err++;
        $display("FAIL async_release cyc %0d: got %b need %b (mask %b)",
                 i, obs() & e[11:6], e[5:0], e[11:6]);
      end
    end
    btn_en = 1'b0;
    idle(10);
  endtask

  initial begin
    test_reset();
    idle($urandom_range(8, 12));
    test_en_press();                  // en ends at 0
    idle($urandom_range(8, 12));
    test_bounce();
    idle($urandom_range(8, 12));
    test_speed_gated();
    idle($urandom_range(8, 12));
    test_simultaneous(1'b0);          // en 0 -> 1, speed dropped
    idle($urandom_range(8, 12));
    test_speed_pulse();
    idle($urandom_range(8, 12));
    test_simultaneous(1'b1);          // en 1 -> 0, one-cycle speed
    idle($urandom_range(8, 12));
    press_en();                       // en back to 1
    idle($urandom_range(8, 12));
    test_abort();                     // en ends at 0
    idle($urandom_range(8, 12));
    press_en();                       // en back to 1
    idle($urandom_range(8, 12));
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
